// File: rtl/sdram_burst_writer.sv
// SDRAM burst write engine: ACTIVATE, WRITE burst, write recovery and precharge
// for one captured request, with every DRAM pin driven from a register.
module sdram_burst_writer #(
    parameter int ROW_W     = 13,
    parameter int COL_W     = 10,
    parameter int BANK_W    = 2,
    parameter int DQ_W      = 16,
    parameter int BURST_LEN = 8,
    parameter int T_RCD     = 2,
    parameter int T_WR      = 2,
    parameter int T_RP      = 2,
    parameter int AUTO_PRE  = 1,
    localparam int DQM_W    = DQ_W / 8
) (
    input  logic                       iclk,
    input  logic                       ireset_n,
    input  logic                       ireq,
    output logic                       oready,
    output logic                       ofin,
    input  logic [ROW_W-1:0]           irow,
    input  logic [COL_W-1:0]           icolumn,
    input  logic [BANK_W-1:0]          ibank,
    input  logic [DQ_W*BURST_LEN-1:0]  idata,
    input  logic [DQM_W*BURST_LEN-1:0] ibyte_en,
    output logic                       DRAM_CKE,
    output logic                       DRAM_CS_N,
    output logic                       DRAM_RAS_N,
    output logic                       DRAM_CAS_N,
    output logic                       DRAM_WE_N,
    output logic [12:0]                DRAM_ADDR,
    output logic [BANK_W-1:0]          DRAM_BA,
    output logic [DQM_W-1:0]           DRAM_DQM,
    output logic [DQ_W-1:0]            DRAM_DQ_OUT,
    output logic                       DRAM_DQ_OE
);
    localparam int T_A   = (T_RCD > BURST_LEN) ? T_RCD : BURST_LEN;
    localparam int T_B   = (T_WR > T_RP) ? T_WR : T_RP;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    localparam logic [COL_W-1:0] COL_MASK = ~COL_W'(BURST_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ACT, S_RCD_WAIT, S_WRITE, S_BURST, S_WR_REC, S_PRE, S_RP_WAIT, S_DONE
    } state_t;

    state_t                     state, state_n;
    logic [CNT_W-1:0]           cnt, cnt_n;
    logic [COL_W-1:0]           col_q;
    logic [BANK_W-1:0]          bank_q;
    logic [DQ_W*BURST_LEN-1:0]  data_q;
    logic [DQM_W*BURST_LEN-1:0] be_q;

    logic [3:0]        cmd_q, cmd_n;
    logic [12:0]       addr_n;
    logic [BANK_W-1:0] ba_n;
    logic [DQM_W-1:0]  dqm_n;
    logic [DQ_W-1:0]   dq_n;
    logic              oe_n;
    int                beat;

    assign oready   = (state == S_IDLE);
    assign ofin     = (state == S_DONE);
    assign DRAM_CKE = 1'b1;
    assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = cmd_q;

    // The counter holds (remaining cycles in the state - 1) and is reloaded on entry.
    always_comb begin
        state_n = state;
        cnt_n   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        case (state)
            S_IDLE:     if (ireq) state_n = S_ACT;
            S_ACT: begin
                if (T_RCD > 1) begin
                    state_n = S_RCD_WAIT;
                    cnt_n   = CNT_W'(T_RCD - 2);
                end else begin
                    state_n = S_WRITE;
                end
            end
            S_RCD_WAIT: if (cnt == '0) state_n = S_WRITE;
            S_WRITE: begin
                if (BURST_LEN > 1) begin
                    state_n = S_BURST;
                    cnt_n   = CNT_W'(BURST_LEN - 2);
                end else begin
                    state_n = S_WR_REC;
                    cnt_n   = CNT_W'(T_WR - 1);
                end
            end
            S_BURST: if (cnt == '0) begin
                state_n = S_WR_REC;
                cnt_n   = CNT_W'(T_WR - 1);
            end
            S_WR_REC: if (cnt == '0) begin
                if (AUTO_PRE != 0) begin
                    state_n = S_RP_WAIT;
                    cnt_n   = CNT_W'(T_RP - 1);
                end else begin
                    state_n = S_PRE;
                end
            end
            S_PRE: begin
                if (T_RP > 1) begin
                    state_n = S_RP_WAIT;
                    cnt_n   = CNT_W'(T_RP - 2);
                end else begin
                    state_n = S_DONE;
                end
            end
            S_RP_WAIT:  if (cnt == '0) state_n = S_DONE;
            S_DONE:     state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    // Pin values are decoded from the state being entered so they register on the same edge.
    always_comb begin
        cmd_n  = CMD_NOP;
        addr_n = '0;
        ba_n   = '0;
        dqm_n  = '1;
        dq_n   = '0;
        oe_n   = 1'b0;
        beat   = -1;
        case (state_n)
            S_ACT: begin
                cmd_n              = CMD_ACT;
                addr_n[ROW_W-1:0]  = irow;
                ba_n               = ibank;
            end
            S_WRITE: begin
                cmd_n              = CMD_WR;
                addr_n[COL_W-1:0]  = col_q;
                addr_n[10]         = (AUTO_PRE != 0);
                ba_n               = bank_q;
                beat               = 0;
            end
            S_BURST: beat = BURST_LEN - 1 - int'(cnt_n);
            S_PRE: begin
                cmd_n = CMD_PRE;
                ba_n  = bank_q;
            end
            default: ;
        endcase
        if (beat >= 0) begin
            oe_n  = 1'b1;
            dq_n  = data_q[beat*DQ_W +: DQ_W];
            dqm_n = ~be_q[beat*DQM_W +: DQM_W];
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            col_q       <= '0;
            bank_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            cmd_q       <= CMD_NOP;
            DRAM_ADDR   <= '0;
            DRAM_BA     <= '0;
            DRAM_DQM    <= '1;
            DRAM_DQ_OUT <= '0;
            DRAM_DQ_OE  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == S_IDLE && ireq) begin
                col_q  <= icolumn & COL_MASK;
                bank_q <= ibank;
                data_q <= idata;
                be_q   <= ibyte_en;
            end
            cmd_q       <= cmd_n;
            DRAM_ADDR   <= addr_n;
            DRAM_BA     <= ba_n;
            DRAM_DQM    <= dqm_n;
            DRAM_DQ_OUT <= dq_n;
            DRAM_DQ_OE  <= oe_n;
        end
    end
endmodule

// File: tb/tb_sdram_burst_writer.sv
// Directed bench for sdram_burst_writer: three parameter sets sharing one clock,
// cycle-by-cycle pin checks against hand-derived timing tables.
module tb_sdram_burst_writer;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, WR = 4'b0100, PRE = 4'b0010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [12:0] row;
    logic [9:0]  col;
    logic [1:0]  bank;

    // u0: defaults (AUTO_PRE=1, BURST_LEN=8)
    logic req0, rdy0, fin0, cke0, cs0, ras0, cas0, we0, oe0;
    logic [127:0] data0;
    logic [15:0]  be0, dq0;
    logic [12:0]  addr0;
    logic [1:0]   ba0, dqm0;

    // u1: AUTO_PRE=0, T_RCD=3, BURST_LEN=4
    logic req1, rdy1, fin1, cke1, cs1, ras1, cas1, we1, oe1;
    logic [63:0] data1;
    logic [7:0]  be1;
    logic [15:0] dq1;
    logic [12:0] addr1;
    logic [1:0]  ba1, dqm1;

    // u2: BURST_LEN=1, T_WR=1, T_RP=1
    logic req2, rdy2, fin2, cke2, cs2, ras2, cas2, we2, oe2;
    logic [15:0] data2, dq2;
    logic [1:0]  be2;
    logic [12:0] addr2;
    logic [1:0]  ba2, dqm2;

    sdram_burst_writer u0 (
        .iclk(clk), .ireset_n(rst_n), .ireq(req0), .oready(rdy0), .ofin(fin0),
        .irow(row), .icolumn(col), .ibank(bank), .idata(data0), .ibyte_en(be0),
        .DRAM_CKE(cke0), .DRAM_CS_N(cs0), .DRAM_RAS_N(ras0), .DRAM_CAS_N(cas0),
        .DRAM_WE_N(we0), .DRAM_ADDR(addr0), .DRAM_BA(ba0), .DRAM_DQM(dqm0),
        .DRAM_DQ_OUT(dq0), .DRAM_DQ_OE(oe0)
    );

    sdram_burst_writer #(.AUTO_PRE(0), .T_RCD(3), .BURST_LEN(4)) u1 (
        .iclk(clk), .ireset_n(rst_n), .ireq(req1), .oready(rdy1), .ofin(fin1),
        .irow(row), .icolumn(col), .ibank(bank), .idata(data1), .ibyte_en(be1),
        .DRAM_CKE(cke1), .DRAM_CS_N(cs1), .DRAM_RAS_N(ras1), .DRAM_CAS_N(cas1),
        .DRAM_WE_N(we1), .DRAM_ADDR(addr1), .DRAM_BA(ba1), .DRAM_DQM(dqm1),
        .DRAM_DQ_OUT(dq1), .DRAM_DQ_OE(oe1)
    );

    sdram_burst_writer #(.BURST_LEN(1), .T_WR(1), .T_RP(1)) u2 (
        .iclk(clk), .ireset_n(rst_n), .ireq(req2), .oready(rdy2), .ofin(fin2),
        .irow(row), .icolumn(col), .ibank(bank), .idata(data2), .ibyte_en(be2),
        .DRAM_CKE(cke2), .DRAM_CS_N(cs2), .DRAM_RAS_N(ras2), .DRAM_CAS_N(cas2),
        .DRAM_WE_N(we2), .DRAM_ADDR(addr2), .DRAM_BA(ba2), .DRAM_DQM(dqm2),
        .DRAM_DQ_OUT(dq2), .DRAM_DQ_OE(oe2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected u0 pins in cycle m of a sequence (defaults: WRITE at 3, beats 3..10, ofin 15).
    task automatic exp0(input int m, input int n, input logic [12:0] r, input logic [9:0] c,
                        input logic [1:0] b, input logic [127:0] d, input logic [15:0] e,
                        input string t);
        logic [3:0] cmd; logic [12:0] a; logic [1:0] eba, edqm; logic eoe; logic [15:0] edq;
        cmd = NOP; a = '0; eba = '0; eoe = 1'b0; edq = '0; edqm = 2'b11;
        if (m == 1) begin cmd = ACT; a = r; eba = b; end
        if (m == 3) begin cmd = WR; a = {2'b00, 1'b1, c[9:3], 3'b000}; eba = b; end
        if (m >= 3 && m <= 10) begin
            eoe = 1'b1; edq = d[(m-3)*16 +: 16]; edqm = ~e[(m-3)*2 +: 2];
        end
        chk($sformatf("%s n%0d cmd", t, n), {28'd0, cs0, ras0, cas0, we0}, {28'd0, cmd});
        chk($sformatf("%s n%0d addr", t, n), {19'd0, addr0}, {19'd0, a});
        chk($sformatf("%s n%0d ba", t, n), {30'd0, ba0}, {30'd0, eba});
        chk($sformatf("%s n%0d oe", t, n), {31'd0, oe0}, {31'd0, eoe});
        chk($sformatf("%s n%0d dq", t, n), {16'd0, dq0}, {16'd0, edq});
        chk($sformatf("%s n%0d dqm", t, n), {30'd0, dqm0}, {30'd0, edqm});
        chk($sformatf("%s n%0d fin", t, n), {31'd0, fin0}, {31'd0, m == 15});
        chk($sformatf("%s n%0d rdy", t, n), {31'd0, rdy0}, {31'd0, m == 16});
        chk($sformatf("%s n%0d cke", t, n), {31'd0, cke0}, 32'd1);
    endtask

    task automatic run0(input logic [12:0] r, input logic [9:0] c, input logic [1:0] b,
                        input logic [127:0] d, input logic [15:0] e, input string t);
        @(negedge clk);
        row = r; col = c; bank = b; data0 = d; be0 = e; req0 = 1'b1;
        @(posedge clk); #1; req0 = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            exp0(n, n, r, c, b, d, e, t);
        end
    endtask

    task automatic chk_reset_pins(input string t);
        chk({t, " cmd"}, {28'd0, cs0, ras0, cas0, we0}, {28'd0, NOP});
        chk({t, " addr"}, {19'd0, addr0}, 32'd0);
        chk({t, " ba"}, {30'd0, ba0}, 32'd0);
        chk({t, " dqm"}, {30'd0, dqm0}, 32'd3);
        chk({t, " oe"}, {31'd0, oe0}, 32'd0);
        chk({t, " dq"}, {16'd0, dq0}, 32'd0);
        chk({t, " fin"}, {31'd0, fin0}, 32'd0);
        chk({t, " rdy"}, {31'd0, rdy0}, 32'd1);
        chk({t, " cke"}, {31'd0, cke0}, 32'd1);
    endtask

    localparam logic [127:0] D_A = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
    localparam logic [127:0] D_B = 128'hF0F0_E1E1_D2D2_C3C3_B4B4_A5A5_9696_8787;

    initial begin
        logic [127:0] dsel;
        logic [15:0]  esel;
        logic [12:0]  rsel;
        logic [9:0]   csel;
        logic [1:0]   bsel;
        req0 = 0; req1 = 0; req2 = 0;
        row = '0; col = '0; bank = '0;
        data0 = '0; be0 = '0; data1 = '0; be1 = '0; data2 = '0; be2 = '0;

        // reset state, with a request pending that must not be accepted
        req0 = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_reset_pins("reset");
        @(negedge clk); req0 = 1'b0; rst_n = 1'b1;

        // defaults, all bytes enabled
        run0(13'h1A5, 10'h028, 2'd2, D_A, 16'hFFFF, "basic");

        // byte enables: beat 2 = 01, beat 5 = 00 -> DQM 10 at n=5, 11 at n=8 with OE
        run0(13'h0F0, 10'h3F8, 2'd1, D_B, 16'b11_11_00_11_11_01_11_11, "bytemask");

        // back-to-back with inputs changed at n=4
        @(negedge clk);
        row = 13'h1A5; col = 10'h028; bank = 2'd2; data0 = D_A; be0 = 16'hFFFF; req0 = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 32; n++) begin
            @(posedge clk); #1;
            if (n == 1) ; // first cycle sampled after the next edge below
        end
        // replay with proper sampling alignment
        @(negedge clk); req0 = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        row = 13'h1A5; col = 10'h028; bank = 2'd2; data0 = D_A; be0 = 16'hFFFF; req0 = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 32; n++) begin
            if (n > 1) @(posedge clk);
            #1;
            if (n == 4) begin
                row = 13'h0ABC; col = 10'h150; bank = 2'd3; data0 = D_B; be0 = 16'hFFFF;
            end
            if (n == 17) req0 = 1'b0;
            if (n <= 16) begin
                rsel = 13'h1A5; csel = 10'h028; bsel = 2'd2; dsel = D_A; esel = 16'hFFFF;
                exp0(n, n, rsel, csel, bsel, dsel, esel, "b2b");
            end else begin
                rsel = 13'h0ABC; csel = 10'h150; bsel = 2'd3; dsel = D_B; esel = 16'hFFFF;
                exp0(n - 16, n, rsel, csel, bsel, dsel, esel, "b2b");
            end
        end

        // mid-burst reset at n=6
        @(negedge clk);
        row = 13'h0042; col = 10'h010; bank = 2'd1; data0 = D_B; be0 = 16'hFFFF; req0 = 1'b1;
        @(posedge clk); #1; req0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("rst mid oe before", {31'd0, oe0}, 32'd1);
        rst_n = 1'b0;
        #1 chk_reset_pins("rst mid");
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst hold%0d fin", i), {31'd0, fin0}, 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        run0(13'h1FFF, 10'h3FF, 2'd3, D_A, 16'hA5C3, "after rst");

        // u1: explicit precharge, T_RCD=3, BURST_LEN=4, column aligned down
        @(negedge clk);
        row = 13'h0777; col = 10'h013; bank = 2'd1; data1 = 64'hDDDD_CCCC_BBBB_AAAA;
        be1 = 8'hFF; req1 = 1'b1;
        @(posedge clk); #1; req1 = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            logic [3:0] cmd; logic [12:0] a; logic [1:0] eba; logic eoe; logic [15:0] edq;
            if (n > 1) begin @(posedge clk); #1; end
            cmd = NOP; a = '0; eba = '0; eoe = 1'b0; edq = '0;
            if (n == 1)  begin cmd = ACT; a = 13'h0777; eba = 2'd1; end
            if (n == 4)  begin cmd = WR;  a = 13'h0010;  eba = 2'd1; end
            if (n == 10) begin cmd = PRE; a = 13'h0000;  eba = 2'd1; end
            if (n >= 4 && n <= 7) begin eoe = 1'b1; edq = data1[(n-4)*16 +: 16]; end
            chk($sformatf("pre n%0d cmd", n), {28'd0, cs1, ras1, cas1, we1}, {28'd0, cmd});
            chk($sformatf("pre n%0d addr", n), {19'd0, addr1}, {19'd0, a});
            chk($sformatf("pre n%0d ba", n), {30'd0, ba1}, {30'd0, eba});
            chk($sformatf("pre n%0d oe", n), {31'd0, oe1}, {31'd0, eoe});
            chk($sformatf("pre n%0d dq", n), {16'd0, dq1}, {16'd0, edq});
            chk($sformatf("pre n%0d dqm", n), {30'd0, dqm1}, eoe ? 32'd0 : 32'd3);
            chk($sformatf("pre n%0d fin", n), {31'd0, fin1}, {31'd0, n == 12});
            chk($sformatf("pre n%0d rdy", n), {31'd0, rdy1}, {31'd0, n == 13});
        end

        // u2: single-beat burst, minimal recovery
        @(negedge clk);
        row = 13'h0101; col = 10'h013; bank = 2'd0; data2 = 16'hBEEF; be2 = 2'b10; req2 = 1'b1;
        @(posedge clk); #1; req2 = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            logic [3:0] cmd; logic [12:0] a; logic eoe;
            if (n > 1) begin @(posedge clk); #1; end
            cmd = NOP; a = '0; eoe = (n == 3);
            if (n == 1) begin cmd = ACT; a = 13'h0101; end
            if (n == 3) begin cmd = WR;  a = 13'h0413; end
            chk($sformatf("bl1 n%0d cmd", n), {28'd0, cs2, ras2, cas2, we2}, {28'd0, cmd});
            chk($sformatf("bl1 n%0d addr", n), {19'd0, addr2}, {19'd0, a});
            chk($sformatf("bl1 n%0d oe", n), {31'd0, oe2}, {31'd0, eoe});
            chk($sformatf("bl1 n%0d dq", n), {16'd0, dq2}, eoe ? 32'hBEEF : 32'd0);
            chk($sformatf("bl1 n%0d dqm", n), {30'd0, dqm2}, eoe ? 32'd1 : 32'd3);
            chk($sformatf("bl1 n%0d fin", n), {31'd0, fin2}, {31'd0, n == 6});
            chk($sformatf("bl1 n%0d rdy", n), {31'd0, rdy2}, {31'd0, n == 7});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
